screen_ctrl: RTL

Frame-synchronous screen-mode controller for the 800x600 @ 40 MHz drawing pipeline. It turns user button presses and a game-over event into a screen state (START, PLAY, PAUSE, OVER). It changes state only at frame boundaries, so the background/overlay drawers never switch mid-frame. It sits beside the timing generator: it takes the timing `vblnk`, and its `bg_sel` drives the mux that picks which background drawer feeds the `vga_if` chain.

---
 rtl/vga_pkg.sv | 12 +
 rtl/edge_rise.sv | 19 +
 rtl/screen_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types for the VGA drawing pipeline.
// screen_t is also the select code for the background drawer mux.
package vga_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'b00,
    SCR_PLAY  = 2'b01,
    SCR_PAUSE = 2'b10,
    SCR_OVER  = 2'b11
  } screen_t;

endpackage

// File: rtl/edge_rise.sv
// One-cycle rising-edge pulse derived from an input and its registered copy.
// The copy resets to 0, so a level already high at reset release yields one pulse.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/screen_ctrl.sv
// Frame-synchronous screen-mode controller: collects button/game-over events
// during a frame and changes screen only on the frame boundary tick.
module screen_ctrl
  import vga_pkg::*;
#(
  parameter int OVER_FRAMES = 120
) (
  input  logic       clk40MHz,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       game_over,
  output logic [1:0] bg_sel,
  output logic       game_en,
  output logic       frame_tick
);

  localparam int               CNT_W    = $clog2(OVER_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVER_FRAMES - 1);

  logic             vblnk_rise;
  logic             start_rise;
  logic             pause_rise;
  logic             pend_start;
  logic             pend_pause;
  logic             pend_over;
  logic             req_start;
  logic             req_pause;
  logic             req_over;
  screen_t          state;
  screen_t          state_next;
  logic [CNT_W-1:0] over_cnt;
  logic [CNT_W-1:0] over_cnt_next;

  edge_rise u_vblnk_edge (
    .clk  (clk40MHz),
    .rst  (rst),
    .d    (vblnk),
    .rise (vblnk_rise)
  );

  edge_rise u_start_edge (
    .clk  (clk40MHz),
    .rst  (rst),
    .d    (btn_start),
    .rise (start_rise)
  );

  edge_rise u_pause_edge (
    .clk  (clk40MHz),
    .rst  (rst),
    .d    (btn_pause),
    .rise (pause_rise)
  );

  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= vblnk_rise;
  end

  // Pending requests: sticky within a frame, consumed (or discarded) on every tick.
  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      pend_start <= 1'b0;
      pend_pause <= 1'b0;
      pend_over  <= 1'b0;
    end else if (frame_tick) begin
      pend_start <= 1'b0;
      pend_pause <= 1'b0;
      pend_over  <= 1'b0;
    end else begin
      pend_start <= pend_start | start_rise;
      pend_pause <= pend_pause | pause_rise;
      pend_over  <= pend_over  | game_over;
    end
  end

  // Events landing in the tick cycle itself still count for this boundary.
  assign req_start = pend_start | start_rise;
  assign req_pause = pend_pause | pause_rise;
  assign req_over  = pend_over  | game_over;

  always_comb begin
    state_next    = state;
    over_cnt_next = over_cnt;
    if (frame_tick) begin
      case (state)
        SCR_START: begin
          if (req_start) state_next = SCR_PLAY;
        end
        SCR_PLAY: begin
          if (req_over) begin
            state_next    = SCR_OVER;
            over_cnt_next = '0;
          end else if (req_pause) begin
            state_next = SCR_PAUSE;
          end
        end
        SCR_PAUSE: begin
          if (req_pause || req_start) state_next = SCR_PLAY;
        end
        SCR_OVER: begin
          if (req_start || (over_cnt == CNT_LAST)) begin
            state_next    = SCR_START;
            over_cnt_next = '0;
          end else begin
            over_cnt_next = over_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next    = SCR_START;
          over_cnt_next = '0;
        end
      endcase
    end
  end

  // Outputs load together with the state so they are visible the cycle after the tick.
  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      state    <= SCR_START;
      over_cnt <= '0;
      bg_sel   <= 2'b00;
      game_en  <= 1'b0;
    end else begin
      state    <= state_next;
      over_cnt <= over_cnt_next;
      bg_sel   <= state_next;
      game_en  <= (state_next == SCR_PLAY);
    end
  end

endmodule
